johnson_sequence_checker: RTL
=============================

Name: johnson_sequence_checker

Overview:
Receive-side companion to the 4-bit Johnson counter. It samples the counter's Q bus and decodes each code to a state number. It validates that every sample is a legal Johnson code one step ahead of the previous sample, and reports lock status, error pulses and a saturating error count. It sits downstream of the counter on the lab board and drives the status LEDs and 7-segment display.

Parameters:
LOCK_COUNT, 3, consecutive correct +1 steps required to go from SYNC to LOCKED (1..7)
ERR_CNT_W, 8, width of ErrorCount

Ports:
CLK  input  1  clock; all state updates on the rising edge (the counter changes on the falling edge)
Reset  input  1  reset, asynchronous, active-low
Sample  input  1  when 1 at a rising edge, Code and Complement are captured and checked
Code  input  4  Johnson code from the counter
Complement  input  1  when 1, Code is inverted before decoding
ClearCount  input  1  synchronous clear of ErrorCount
StateNumber  output  3  decoded state of the last legal sample
Valid  output  1  last sample was a legal code
Locked  output  1  FSM is in LOCKED
CodeError  output  1  one-cycle pulse: illegal code sampled
StepError  output  1  one-cycle pulse: legal code, but not the previous state + 1 mod 8
ErrorCount  output  ERR_CNT_W  saturating count of CodeError and StepError events

Behaviour:
- Reset=0 (any time, including mid-sequence): FSM=HUNT, run counter=0, prev=0; StateNumber=0, Valid=0, Locked=0, CodeError=0, StepError=0, ErrorCount=0.
- Effective code: c = Complement ? ~Code : Code.
- Decode table: 0000->0, 1000->1, 1100->2, 1110->3, 1111->4, 0111->5, 0011->6, 0001->7. The other 8 codes (e.g. 0100, 1010, 1001) are illegal.
- Latency: every output is registered and updates at the same rising edge where Sample=1 is seen. With Sample=0, all outputs hold, except the error pulses, which return to 0.
- On a legal sample, StateNumber and prev take the decoded value and Valid=1. On an illegal sample, StateNumber holds and Valid=0.
- Expected step: decoded == prev + 1, 3-bit wrap (7->0 is legal). A repeated value is a step error.
- FSM, evaluated only when Sample=1:
  - HUNT:
    - legal -> SYNC, run=0.
    - illegal -> stay in HUNT, CodeError.
  - SYNC:
    - legal and correct step -> run+1; if run+1 == LOCK_COUNT, go to LOCKED.
    - legal and wrong step -> StepError, run=0, stay in SYNC (the new value becomes prev).
    - illegal -> CodeError, go to HUNT.
  - LOCKED:
    - correct step -> stay in LOCKED.
    - wrong step -> StepError, go to SYNC, run=0.
    - illegal -> CodeError, go to HUNT.
  - Locked = 1 only in LOCKED.
- A StepError is never raised on the first legal sample after HUNT.
- ErrorCount: +1 on each CodeError or StepError. At most one can occur per sample. Saturates at 2^ERR_CNT_W-1.
- ClearCount=1 sets ErrorCount to 0 at the next edge. If ClearCount coincides with an error, the clear wins: count=0 and that error is not counted, though its pulse is still output.
- Complement toggling between samples is handled per sample. Complementing a running counter shifts the state by 4, so it produces one StepError unless the bench toggles both ends consistently.

Decomposition:
- Shared package johnson_pkg:
  - FSM state encoding: HUNT=2'd0, SYNC=2'd1, LOCKED=2'd2.
  - Legal code table constants.
  - Function johnson_decode(code) -> {legal, state[2:0]}, the single source of truth, also reusable by the counter's bench.
- One combinational sub-module, johnson_code_decoder: inputs Code and Complement; outputs legal and state[2:0]. The checker holds the FSM, run counter, prev register and error counter.

Test Plan:
- Reset, then Sample the codes 0000,1000,1100,1110 (LOCK_COUNT=3) -> StateNumber 0,1,2,3; Locked=1 after the 4th sample; no errors; ErrorCount=0.
- While locked, feed 1111,0111,0011,0001,0000 -> wrap 7->0 accepted; Locked stays 1; StateNumber ends at 0.
- While locked at state 2, sample 1111 (state 4) -> StepError pulse for 1 cycle; Locked=0; ErrorCount=1; StateNumber=4; relock after 3 more correct steps.
- Sample 1010 -> CodeError pulse; Valid=0; StateNumber holds; FSM=HUNT; ErrorCount+1. Next sample 0011 -> Valid=1; StateNumber=6; no StepError.
- Complement=1 with Code=1111,0111,0011,0001 -> decoded 0,1,2,3; locks normally.
- ERR_CNT_W=2: inject 5 illegal codes -> ErrorCount saturates at 3. Then ClearCount together with an illegal code -> ErrorCount=0 and the CodeError pulse is still output. Then assert Reset=0 mid-stream, between edges -> all outputs go to 0 immediately.

Source files
------------

// File: rtl/johnson_pkg.sv
// Shared definitions for the 4-bit Johnson counter receive-side checker.
//   - chk_state_e    : checker FSM encoding (HUNT / SYNC / LOCKED)
//   - JohnsonS0..S7  : the eight legal Johnson codes, in counting order
//   - johnson_decode : code -> {legal, state[2:0]}; single source of truth
package johnson_pkg;

  typedef enum logic [1:0] {
    StHunt   = 2'd0,
    StSync   = 2'd1,
    StLocked = 2'd2
  } chk_state_e;

  localparam logic [3:0] JohnsonS0 = 4'b0000;
  localparam logic [3:0] JohnsonS1 = 4'b1000;
  localparam logic [3:0] JohnsonS2 = 4'b1100;
  localparam logic [3:0] JohnsonS3 = 4'b1110;
  localparam logic [3:0] JohnsonS4 = 4'b1111;
  localparam logic [3:0] JohnsonS5 = 4'b0111;
  localparam logic [3:0] JohnsonS6 = 4'b0011;
  localparam logic [3:0] JohnsonS7 = 4'b0001;

  // Returns {legal, state}; illegal codes return {1'b0, 3'd0}.
  function automatic logic [3:0] johnson_decode(input logic [3:0] code);
    logic [3:0] res;
    case (code)
      JohnsonS0: res = {1'b1, 3'd0};
      JohnsonS1: res = {1'b1, 3'd1};
      JohnsonS2: res = {1'b1, 3'd2};
      JohnsonS3: res = {1'b1, 3'd3};
      JohnsonS4: res = {1'b1, 3'd4};
      JohnsonS5: res = {1'b1, 3'd5};
      JohnsonS6: res = {1'b1, 3'd6};
      JohnsonS7: res = {1'b1, 3'd7};
      default:   res = {1'b0, 3'd0};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/johnson_sequence_checker_if.sv
// Sample/status bundle between the Johnson counter side and the checker.
//   master : drives Sample, Code, Complement, ClearCount; observes status
//   slave  : the checker; receives sample inputs, drives status outputs
interface johnson_sequence_checker_if #(
  parameter int unsigned ERR_CNT_W = 8
);
  logic                 Sample;
  logic [3:0]           Code;
  logic                 Complement;
  logic                 ClearCount;
  logic [2:0]           StateNumber;
  logic                 Valid;
  logic                 Locked;
  logic                 CodeError;
  logic                 StepError;
  logic [ERR_CNT_W-1:0] ErrorCount;

  modport master (
    output Sample, Code, Complement, ClearCount,
    input  StateNumber, Valid, Locked, CodeError, StepError, ErrorCount
  );

  modport slave (
    input  Sample, Code, Complement, ClearCount,
    output StateNumber, Valid, Locked, CodeError, StepError, ErrorCount
  );
endinterface

// File: rtl/johnson_code_decoder.sv
// Combinational Johnson code decoder.
//   Code       : raw 4-bit code from the counter
//   Complement : invert Code before decoding
//   legal      : code is one of the eight Johnson codes
//   state      : decoded state number (0 when illegal)
module johnson_code_decoder
  import johnson_pkg::*;
(
  input  logic [3:0] Code,
  input  logic       Complement,
  output logic       legal,
  output logic [2:0] state
);

  logic [3:0] eff_code;
  logic [3:0] dec;

  always_comb begin
    eff_code = Complement ? ~Code : Code;
    dec      = johnson_decode(eff_code);
    legal    = dec[3];
    state    = dec[2:0];
  end

endmodule

// File: rtl/johnson_sequence_checker.sv
// Receive-side checker for the 4-bit Johnson counter. Each sampled code is
// decoded and must be a legal code exactly one state ahead (mod 8) of the
// previous legal sample. Tracks lock, pulses errors and counts them.
//   CLK    : rising-edge clock (counter updates on the falling edge)
//   Reset  : asynchronous, active-low
//   bus    : slave side of johnson_sequence_checker_if (sample inputs, status)
module johnson_sequence_checker
  import johnson_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 3,
  parameter int unsigned ERR_CNT_W  = 8
) (
  input logic                        CLK,
  input logic                        Reset,
  johnson_sequence_checker_if.slave  bus
);

  localparam logic [2:0]           LockCnt = 3'(LOCK_COUNT);
  localparam logic [ERR_CNT_W-1:0] CntMax  = '1;

  logic       dec_legal;
  logic [2:0] dec_state;

  johnson_code_decoder u_decoder (
    .Code       (bus.Code),
    .Complement (bus.Complement),
    .legal      (dec_legal),
    .state      (dec_state)
  );

  chk_state_e           state_q, state_d;
  logic [2:0]           run_q, run_d;
  logic [2:0]           prev_q, prev_d;
  logic [2:0]           snum_q, snum_d;
  logic                 valid_q, valid_d;
  logic                 code_err_q, code_err_d;
  logic                 step_err_q, step_err_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0] prev_inc;
  logic [2:0] run_inc;
  logic       step_ok;

  // State register
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q    <= StHunt;
      run_q      <= '0;
      prev_q     <= '0;
      snum_q     <= '0;
      valid_q    <= 1'b0;
      code_err_q <= 1'b0;
      step_err_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      prev_q     <= prev_d;
      snum_q     <= snum_d;
      valid_q    <= valid_d;
      code_err_q <= code_err_d;
      step_err_q <= step_err_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    prev_d     = prev_q;
    snum_d     = snum_q;
    valid_d    = valid_q;
    code_err_d = 1'b0;
    step_err_d = 1'b0;
    prev_inc   = prev_q + 3'd1;
    run_inc    = run_q + 3'd1;
    step_ok    = (dec_state == prev_inc);

    if (bus.Sample) begin
      valid_d = dec_legal;
      if (dec_legal) begin
        snum_d = dec_state;
        prev_d = dec_state;
      end

      case (state_q)
        StHunt: begin
          // First legal code only establishes the reference; no step check.
          run_d = '0;
          if (dec_legal) begin
            state_d = StSync;
          end else begin
            code_err_d = 1'b1;
          end
        end
        StSync: begin
          if (!dec_legal) begin
            code_err_d = 1'b1;
            state_d    = StHunt;
            run_d      = '0;
          end else if (step_ok) begin
            run_d = run_inc;
            if (run_inc == LockCnt) begin
              state_d = StLocked;
              run_d   = '0;
            end
          end else begin
            step_err_d = 1'b1;
            run_d      = '0;
          end
        end
        StLocked: begin
          if (!dec_legal) begin
            code_err_d = 1'b1;
            state_d    = StHunt;
            run_d      = '0;
          end else if (!step_ok) begin
            step_err_d = 1'b1;
            state_d    = StSync;
            run_d      = '0;
          end
        end
        default: begin
          state_d = StHunt;
          run_d   = '0;
        end
      endcase
    end

    // Clear beats a coincident error; the pulse itself is unaffected.
    if (bus.ClearCount) begin
      cnt_d = '0;
    end else if ((code_err_d || step_err_d) && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Outputs
  always_comb begin
    bus.StateNumber = snum_q;
    bus.Valid       = valid_q;
    bus.Locked      = (state_q == StLocked);
    bus.CodeError   = code_err_q;
    bus.StepError   = step_err_q;
    bus.ErrorCount  = cnt_q;
  end

endmodule
